msu_cmd_scheduler: RTL and testbench
====================================

# msu_cmd_scheduler

Sequences MSU-1 audio requests onto the single HPS ext command channel. Latches track, jump-sector and next-sector requests from the MSU core, then issues them one at a time in priority order as 48-bit command words with a valid/ready handshake. It tracks the outstanding track mount until the HPS answers, and drives the mounting/missing status the MSU core consumes. It sits between the MSU-1 core and the HPS ext message logic, so that back-to-back requests are never overwritten.

## Interface
Parameters:
- TIMEOUT_CYCLES, 32'd100_000_000: mount watchdog limit in clk_sys cycles. Used only with the watchdog macro.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- msu_trackrequest  in  1  level; a rising edge requests a track mount
- msu_trackout  in  16  track number, sampled on the track edge
- msu_audio_jump_sector  in  1  level; a rising edge requests a seek
- msu_audio_sector  in  32  seek sector, sampled on the jump edge
- msu_audio_req  in  1  level; a rising edge requests the next sector
- cmd_valid  out  1  command word available
- cmd_data  out  48  command word
- cmd_ready  in  1  channel accepts; transfer when cmd_valid & cmd_ready
- rsp_valid  in  1  one-cycle strobe carrying a decoded HPS response
- rsp_code  in  16  response code: 'h201 = mounted, 'h401 = missing
- msu_trackmounting  out  1  mount outstanding
- msu_trackmissing  out  1  last mount failed
- sched_busy  out  1  state ≠ IDLE, or any request pending
- timeout_err  out  1  sticky mount-timeout flag

## Operation
- Edge detectors are one register per request input. During reset they load the current input level, so no edge is detected on reset release.
- Each detected edge sets a pending flag and captures its argument. A later edge of the same type overwrites the argument; the latest request wins.
- A track edge clears any jump and sector pending flags set in earlier cycles. A jump or sector edge in the same cycle as the track edge is kept.
- A jump edge clears an earlier pending sector flag.
- Sector edges are discarded while msu_trackmounting = 1 or while a track is pending.
- Command encodings:
  - track: {16'h0, track, 16'h35}
  - jump: {sector, 16'h36}
  - sector: 48'h34
- States: IDLE, ISSUE, WAIT_MOUNT.
- IDLE: if any request is pending, pick by priority track > jump > sector, load cmd_data, clear that pending flag, and go to ISSUE.
- ISSUE: hold cmd_valid = 1 with cmd_data stable until cmd_ready.
  - On a track handshake: go to WAIT_MOUNT, set msu_trackmounting = 1, clear msu_trackmissing and timeout_err.
  - On any other handshake: go to IDLE.
- WAIT_MOUNT: issues no commands. Jump and track edges are still latched.
  - rsp_valid with 'h201: mounting = 0, missing = 0, go to IDLE. Any pending jump is then issued.
  - rsp_valid with 'h401: mounting = 0, missing = 1, pending jump discarded, go to IDLE.
  - Any other rsp_code is ignored.
- A new track pending when WAIT_MOUNT exits is issued next. msu_trackmounting goes back to 1 on its handshake.

## Timing
- Reset values: cmd_valid = 0, cmd_data = 0, msu_trackmounting = 0, msu_trackmissing = 0, sched_busy = 0, timeout_err = 0. State = IDLE; all pending flags cleared.
- Reset applies in the cycle after it is sampled, including mid-ISSUE and mid-WAIT_MOUNT. An outstanding command is dropped without waiting for cmd_ready.
- Latency: edge on input sampled at cycle N → pending flag set at N+1 → cmd_valid = 1 at N+2 (if IDLE).
- If cmd_ready = 1 at N+2, cmd_valid = 0 at N+3. The next command can be valid at N+4 at the earliest.
- cmd_valid never drops without a handshake, except on reset.
- A response at cycle M produces the status update and IDLE at M+1.
- A response in the same cycle as the track handshake is ignored.

## Configuration
- MSU_CMD_TIMEOUT_EN defined:
  - A 32-bit counter clears on entry to WAIT_MOUNT and increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no mount response: timeout_err = 1, missing = 1, mounting = 0, pending jump discarded, go to IDLE.
  - A response arriving in the timeout cycle wins over the timeout.
- MSU_CMD_TIMEOUT_EN undefined: no counter; WAIT_MOUNT waits indefinitely; timeout_err is tied to 0.

## Test plan
- Sector rising edge with cmd_ready held 1 → cmd_valid pulses one cycle at edge+2 with cmd_data = 48'h34; sched_busy returns to 0.
- Track 16'h0007 and jump 32'h0000_1000 edges in the same cycle, cmd_ready = 1:
  - First command is 48'h0000_0007_0035 and msu_trackmounting = 1.
  - A sector edge during WAIT_MOUNT produces no command.
  - rsp 'h201 → next command is 48'h0000_1000_0036.
- Jump edge, then track edge 16'h0003, with cmd_ready = 0 → only the track command is presented. After rsp 'h401, msu_trackmissing = 1 and no jump command is ever issued.
- cmd_ready held 0 for 20 cycles → cmd_valid and cmd_data remain stable. Reset asserted mid-hold → cmd_valid = 0 next cycle and all pending requests are lost.
- With MSU_CMD_TIMEOUT_EN and TIMEOUT_CYCLES = 16: track issued, no response → after 16 cycles timeout_err = 1, msu_trackmissing = 1. The next track handshake clears both.

Source files
------------

// File: rtl/msu_cmd_scheduler.sv
// MSU-1 request scheduler: latches track/jump/sector requests and serialises them onto the HPS ext command channel.
// Optional mount watchdog enabled by defining MSU_CMD_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module msu_cmd_scheduler #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        msu_trackrequest,
    input  logic [15:0] msu_trackout,
    input  logic        msu_audio_jump_sector,
    input  logic [31:0] msu_audio_sector,
    input  logic        msu_audio_req,
    output logic        cmd_valid,
    output logic [47:0] cmd_data,
    input  logic        cmd_ready,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_code,
    output logic        msu_trackmounting,
    output logic        msu_trackmissing,
    output logic        sched_busy,
    output logic        timeout_err
);

    localparam int unsigned CMD_W   = 48;
    localparam int unsigned TRACK_W = 16;
    localparam int unsigned SECT_W  = 32;

    localparam logic [15:0] OP_SECTOR   = 16'h0034;
    localparam logic [15:0] OP_TRACK    = 16'h0035;
    localparam logic [15:0] OP_JUMP     = 16'h0036;
    localparam logic [15:0] RSP_MOUNTED = 16'h0201;
    localparam logic [15:0] RSP_MISSING = 16'h0401;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT_MOUNT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic               r_trk_d, r_jmp_d, r_sec_d;
    logic               r_trk_pend, r_jmp_pend, r_sec_pend;
    logic [TRACK_W-1:0] r_trk_num;
    logic [SECT_W-1:0]  r_jmp_sector;
    logic               r_issue_trk;
    logic               r_cmd_valid;
    logic [CMD_W-1:0]   r_cmd_data;
    logic               r_mounting, r_missing, r_busy, r_timeout_err;

    logic               w_trk_pend_nxt, w_jmp_pend_nxt, w_sec_pend_nxt;
    logic [TRACK_W-1:0] w_trk_num_nxt;
    logic [SECT_W-1:0]  w_jmp_sector_nxt;
    logic               w_issue_trk_nxt;
    logic               w_cmd_valid_nxt;
    logic [CMD_W-1:0]   w_cmd_data_nxt;
    logic               w_mounting_nxt, w_missing_nxt, w_busy_nxt, w_timeout_err_nxt;

    logic w_trk_edge, w_jmp_edge, w_sec_edge;
    logic w_hs, w_any_pend, w_rsp_ok, w_rsp_miss, w_timeout;

    assign w_trk_edge = msu_trackrequest & ~r_trk_d;
    assign w_jmp_edge = msu_audio_jump_sector & ~r_jmp_d;
    assign w_sec_edge = msu_audio_req & ~r_sec_d;
    assign w_hs       = r_cmd_valid & cmd_ready;
    assign w_any_pend = r_trk_pend | r_jmp_pend | r_sec_pend;
    assign w_rsp_ok   = rsp_valid && (rsp_code == RSP_MOUNTED);
    assign w_rsp_miss = rsp_valid && (rsp_code == RSP_MISSING);

`ifdef MSU_CMD_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    // Watchdog counts cycles spent waiting for the mount answer
    always_ff @(posedge clk_sys) begin
        if (reset)
            r_to_cnt <= 32'd0;
        else if (w_hs && r_issue_trk)
            r_to_cnt <= 32'd0;
        else if (r_state == S_WAIT_MOUNT)
            r_to_cnt <= r_to_cnt + 32'd1;
    end

    assign w_timeout = (r_state == S_WAIT_MOUNT) && (r_to_cnt == TIMEOUT_CYCLES - 32'd1);
`else
    logic w_unused_timeout_cycles;
    assign w_unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:
                if (w_any_pend)
                    w_state_nxt = S_ISSUE;
            S_ISSUE:
                if (w_hs)
                    w_state_nxt = r_issue_trk ? S_WAIT_MOUNT : S_IDLE;
            S_WAIT_MOUNT:
                if (w_rsp_ok || w_rsp_miss || w_timeout)
                    w_state_nxt = S_IDLE;
            default:
                w_state_nxt = S_IDLE;
        endcase
    end

    // Output / request bookkeeping; new edges are applied last so they win over clears
    always_comb begin
        w_trk_pend_nxt    = r_trk_pend;
        w_jmp_pend_nxt    = r_jmp_pend;
        w_sec_pend_nxt    = r_sec_pend;
        w_trk_num_nxt     = r_trk_num;
        w_jmp_sector_nxt  = r_jmp_sector;
        w_issue_trk_nxt   = r_issue_trk;
        w_cmd_valid_nxt   = r_cmd_valid;
        w_cmd_data_nxt    = r_cmd_data;
        w_mounting_nxt    = r_mounting;
        w_missing_nxt     = r_missing;
        w_timeout_err_nxt = r_timeout_err;

        case (r_state)
            S_IDLE: begin
                if (r_trk_pend) begin
                    w_trk_pend_nxt  = 1'b0;
                    w_issue_trk_nxt = 1'b1;
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_data_nxt  = {16'h0000, r_trk_num, OP_TRACK};
                end else if (r_jmp_pend) begin
                    w_jmp_pend_nxt  = 1'b0;
                    w_issue_trk_nxt = 1'b0;
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_data_nxt  = {r_jmp_sector, OP_JUMP};
                end else if (r_sec_pend) begin
                    w_sec_pend_nxt  = 1'b0;
                    w_issue_trk_nxt = 1'b0;
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_data_nxt  = CMD_W'(OP_SECTOR);
                end
            end
            S_ISSUE: begin
                if (w_hs) begin
                    w_cmd_valid_nxt = 1'b0;
                    if (r_issue_trk) begin
                        w_mounting_nxt    = 1'b1;
                        w_missing_nxt     = 1'b0;
                        w_timeout_err_nxt = 1'b0;
                    end
                end
            end
            S_WAIT_MOUNT: begin
                if (w_rsp_ok) begin
                    w_mounting_nxt = 1'b0;
                    w_missing_nxt  = 1'b0;
                end else if (w_rsp_miss || w_timeout) begin
                    w_mounting_nxt = 1'b0;
                    w_missing_nxt  = 1'b1;
                    w_jmp_pend_nxt = 1'b0;
                    if (!w_rsp_miss)
                        w_timeout_err_nxt = 1'b1;
                end
            end
            default: ;
        endcase

        if (w_trk_edge) begin
            w_trk_pend_nxt = 1'b1;
            w_trk_num_nxt  = msu_trackout;
            w_jmp_pend_nxt = 1'b0;
            w_sec_pend_nxt = 1'b0;
        end
        if (w_jmp_edge) begin
            w_jmp_pend_nxt   = 1'b1;
            w_jmp_sector_nxt = msu_audio_sector;
            w_sec_pend_nxt   = 1'b0;
        end
        if (w_sec_edge && !r_mounting && !r_trk_pend)
            w_sec_pend_nxt = 1'b1;

        w_busy_nxt = (w_state_nxt != S_IDLE) | w_trk_pend_nxt | w_jmp_pend_nxt | w_sec_pend_nxt;
    end

    // Datapath and registered outputs; edge detectors track the inputs through reset
    always_ff @(posedge clk_sys) begin
        r_trk_d <= msu_trackrequest;
        r_jmp_d <= msu_audio_jump_sector;
        r_sec_d <= msu_audio_req;
        if (reset) begin
            r_trk_pend    <= 1'b0;
            r_jmp_pend    <= 1'b0;
            r_sec_pend    <= 1'b0;
            r_trk_num     <= '0;
            r_jmp_sector  <= '0;
            r_issue_trk   <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_cmd_data    <= '0;
            r_mounting    <= 1'b0;
            r_missing     <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_trk_pend    <= w_trk_pend_nxt;
            r_jmp_pend    <= w_jmp_pend_nxt;
            r_sec_pend    <= w_sec_pend_nxt;
            r_trk_num     <= w_trk_num_nxt;
            r_jmp_sector  <= w_jmp_sector_nxt;
            r_issue_trk   <= w_issue_trk_nxt;
            r_cmd_valid   <= w_cmd_valid_nxt;
            r_cmd_data    <= w_cmd_data_nxt;
            r_mounting    <= w_mounting_nxt;
            r_missing     <= w_missing_nxt;
            r_busy        <= w_busy_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign cmd_valid         = r_cmd_valid;
    assign cmd_data          = r_cmd_data;
    assign msu_trackmounting = r_mounting;
    assign msu_trackmissing  = r_missing;
    assign sched_busy        = r_busy;
    assign timeout_err       = r_timeout_err;

endmodule

// File: tb/tb_msu_cmd_scheduler.sv
// Directed self-checking bench for msu_cmd_scheduler; the timeout scenario depends on MSU_CMD_TIMEOUT_EN.
module tb_msu_cmd_scheduler;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        msu_trackrequest;
    logic [15:0] msu_trackout;
    logic        msu_audio_jump_sector;
    logic [31:0] msu_audio_sector;
    logic        msu_audio_req;
    logic        cmd_valid;
    logic [47:0] cmd_data;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [15:0] rsp_code;
    logic        msu_trackmounting;
    logic        msu_trackmissing;
    logic        sched_busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    msu_cmd_scheduler #(.TIMEOUT_CYCLES(32'd16)) dut (
        .clk_sys               (clk_sys),
        .reset                 (reset),
        .msu_trackrequest      (msu_trackrequest),
        .msu_trackout          (msu_trackout),
        .msu_audio_jump_sector (msu_audio_jump_sector),
        .msu_audio_sector      (msu_audio_sector),
        .msu_audio_req         (msu_audio_req),
        .cmd_valid             (cmd_valid),
        .cmd_data              (cmd_data),
        .cmd_ready             (cmd_ready),
        .rsp_valid             (rsp_valid),
        .rsp_code              (rsp_code),
        .msu_trackmounting     (msu_trackmounting),
        .msu_trackmissing      (msu_trackmissing),
        .sched_busy            (sched_busy),
        .timeout_err           (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b exp 0", cmd_valid); end
        total++; if (cmd_data !== 48'h0) begin bad++; $display("FAIL rst_data got %h exp 0", cmd_data); end
        total++; if (msu_trackmounting !== 1'b0) begin bad++; $display("FAIL rst_mounting got %b exp 0", msu_trackmounting); end
        total++; if (msu_trackmissing !== 1'b0) begin bad++; $display("FAIL rst_missing got %b exp 0", msu_trackmissing); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b exp 0", sched_busy); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout got %b exp 0", timeout_err); end
    endtask

    task automatic test_sector();
        cmd_ready = 1'b1;
        msu_audio_req = 1'b1;
        tick();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL sec_valid_n1 got %b exp 0", cmd_valid); end
        total++; if (sched_busy !== 1'b1) begin bad++; $display("FAIL sec_busy_n1 got %b exp 1", sched_busy); end
        tick();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL sec_valid_n2 got %b exp 1", cmd_valid); end
        total++; if (cmd_data !== 48'h0000_0000_0034) begin bad++; $display("FAIL sec_data got %h exp 000000000034", cmd_data); end
        tick();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL sec_valid_n3 got %b exp 0", cmd_valid); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL sec_busy_n3 got %b exp 0", sched_busy); end
        msu_audio_req = 1'b0;
        tick();
    endtask

    task automatic test_track_jump();
        logic saw_valid;
        cmd_ready = 1'b1;
        msu_trackout = 16'h0007;
        msu_trackrequest = 1'b1;
        msu_audio_sector = 32'h0000_1000;
        msu_audio_jump_sector = 1'b1;
        tick();
        msu_trackrequest = 1'b0;
        msu_audio_jump_sector = 1'b0;
        tick();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL tj_trk_valid got %b exp 1", cmd_valid); end
        total++; if (cmd_data !== 48'h0000_0007_0035) begin bad++; $display("FAIL tj_trk_data got %h exp 000000070035", cmd_data); end
        tick();
        total++; if (msu_trackmounting !== 1'b1) begin bad++; $display("FAIL tj_mounting got %b exp 1", msu_trackmounting); end
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL tj_valid_after_hs got %b exp 0", cmd_valid); end
        msu_audio_req = 1'b1;
        rsp_valid = 1'b1;
        rsp_code = 16'h0123;
        tick();
        rsp_valid = 1'b0;
        saw_valid = cmd_valid;
        for (int i = 0; i < 5; i++) begin
            tick();
            saw_valid = saw_valid | cmd_valid;
        end
        total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL tj_wait_no_cmd got %b exp 0", saw_valid); end
        total++; if (msu_trackmounting !== 1'b1) begin bad++; $display("FAIL tj_other_rsp got %b exp 1", msu_trackmounting); end
        rsp_valid = 1'b1;
        rsp_code = 16'h0201;
        tick();
        rsp_valid = 1'b0;
        total++; if (msu_trackmounting !== 1'b0) begin bad++; $display("FAIL tj_mounted got %b exp 0", msu_trackmounting); end
        total++; if (msu_trackmissing !== 1'b0) begin bad++; $display("FAIL tj_missing got %b exp 0", msu_trackmissing); end
        tick();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL tj_jmp_valid got %b exp 1", cmd_valid); end
        total++; if (cmd_data !== 48'h0000_1000_0036) begin bad++; $display("FAIL tj_jmp_data got %h exp 000010000036", cmd_data); end
        tick();
        saw_valid = cmd_valid;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_valid = saw_valid | cmd_valid;
        end
        total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL tj_sector_dropped got %b exp 0", saw_valid); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL tj_busy_end got %b exp 0", sched_busy); end
        msu_audio_req = 1'b0;
        tick();
    endtask

    task automatic test_jump_then_track();
        logic saw_valid;
        logic stable;
        cmd_ready = 1'b1;
        msu_trackout = 16'h0001;
        msu_trackrequest = 1'b1;
        tick();
        msu_trackrequest = 1'b0;
        tick();
        tick();
        total++; if (msu_trackmounting !== 1'b1) begin bad++; $display("FAIL jt_mount1 got %b exp 1", msu_trackmounting); end
        cmd_ready = 1'b0;
        msu_audio_sector = 32'h0000_0055;
        msu_audio_jump_sector = 1'b1;
        tick();
        msu_trackout = 16'h0003;
        msu_trackrequest = 1'b1;
        tick();
        msu_audio_jump_sector = 1'b0;
        msu_trackrequest = 1'b0;
        rsp_valid = 1'b1;
        rsp_code = 16'h0201;
        tick();
        rsp_valid = 1'b0;
        tick();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL jt_trk_valid got %b exp 1", cmd_valid); end
        total++; if (cmd_data !== 48'h0000_0003_0035) begin bad++; $display("FAIL jt_trk_data got %h exp 000000030035", cmd_data); end
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cmd_valid !== 1'b1 || cmd_data !== 48'h0000_0003_0035) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL jt_hold got %b exp 1", stable); end
        cmd_ready = 1'b1;
        tick();
        total++; if (msu_trackmounting !== 1'b1) begin bad++; $display("FAIL jt_mount2 got %b exp 1", msu_trackmounting); end
        rsp_valid = 1'b1;
        rsp_code = 16'h0401;
        tick();
        rsp_valid = 1'b0;
        total++; if (msu_trackmissing !== 1'b1) begin bad++; $display("FAIL jt_missing got %b exp 1", msu_trackmissing); end
        total++; if (msu_trackmounting !== 1'b0) begin bad++; $display("FAIL jt_mount_clr got %b exp 0", msu_trackmounting); end
        saw_valid = cmd_valid;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw_valid = saw_valid | cmd_valid;
        end
        total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL jt_no_jump got %b exp 0", saw_valid); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL jt_busy_end got %b exp 0", sched_busy); end
    endtask

    task automatic test_stall_reset();
        logic stable;
        logic saw_valid;
        cmd_ready = 1'b0;
        msu_audio_req = 1'b1;
        tick();
        tick();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL sr_valid got %b exp 1", cmd_valid); end
        msu_audio_sector = 32'h0000_0077;
        msu_audio_jump_sector = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cmd_valid !== 1'b1 || cmd_data !== 48'h0000_0000_0034) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL sr_hold20 got %b exp 1", stable); end
        total++; if (sched_busy !== 1'b1) begin bad++; $display("FAIL sr_busy_hold got %b exp 1", sched_busy); end
        reset = 1'b1;
        tick();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL sr_valid_rst got %b exp 0", cmd_valid); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL sr_busy_rst got %b exp 0", sched_busy); end
        total++; if (cmd_data !== 48'h0) begin bad++; $display("FAIL sr_data_rst got %h exp 0", cmd_data); end
        reset = 1'b0;
        cmd_ready = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw_valid = saw_valid | cmd_valid;
        end
        total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL sr_lost got %b exp 0", saw_valid); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL sr_busy_after got %b exp 0", sched_busy); end
        msu_audio_req = 1'b0;
        msu_audio_jump_sector = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        cmd_ready = 1'b1;
        msu_trackout = 16'h0009;
        msu_trackrequest = 1'b1;
        tick();
        msu_trackrequest = 1'b0;
        tick();
        total++; if (cmd_data !== 48'h0000_0009_0035) begin bad++; $display("FAIL to_trk_data got %h exp 000000090035", cmd_data); end
        tick();
`ifdef MSU_CMD_TIMEOUT_EN
        repeat (15) tick();
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_early got %b exp 0", timeout_err); end
        total++; if (msu_trackmounting !== 1'b1) begin bad++; $display("FAIL to_mount_early got %b exp 1", msu_trackmounting); end
        tick();
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err got %b exp 1", timeout_err); end
        total++; if (msu_trackmissing !== 1'b1) begin bad++; $display("FAIL to_missing got %b exp 1", msu_trackmissing); end
        total++; if (msu_trackmounting !== 1'b0) begin bad++; $display("FAIL to_mount_clr got %b exp 0", msu_trackmounting); end
        msu_trackout = 16'h000a;
        msu_trackrequest = 1'b1;
        tick();
        msu_trackrequest = 1'b0;
        tick();
        tick();
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_err_clr got %b exp 0", timeout_err); end
        total++; if (msu_trackmissing !== 1'b0) begin bad++; $display("FAIL to_missing_clr got %b exp 0", msu_trackmissing); end
`else
        repeat (20) tick();
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_tied got %b exp 0", timeout_err); end
        total++; if (msu_trackmounting !== 1'b1) begin bad++; $display("FAIL to_still_mount got %b exp 1", msu_trackmounting); end
`endif
        rsp_valid = 1'b1;
        rsp_code = 16'h0201;
        tick();
        rsp_valid = 1'b0;
        total++; if (msu_trackmounting !== 1'b0) begin bad++; $display("FAIL to_final_mount got %b exp 0", msu_trackmounting); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        msu_trackrequest = 1'b0;
        msu_trackout = 16'h0;
        msu_audio_jump_sector = 1'b0;
        msu_audio_sector = 32'h0;
        msu_audio_req = 1'b0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_code = 16'h0;
        repeat (3) tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_sector();
        test_track_jump();
        test_jump_then_track();
        test_stall_reset();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
